ex_branch_resolve: RTL and testbench
====================================

EX_BRANCH_RESOLVE -- requirements
Module: ex_branch_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter SQUASH_CYCLES, default 2, advance cycles of front-end flush per redirect (legal 1..3).
REQ-003 SHALL have port Clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port ClockEnable  in  1  pipeline enable.
REQ-006 SHALL have port Tick  in  1  clock-divider tick; advance = ClockEnable & Tick.
REQ-007 SHALL have port valid_ex  in  1  EX slot holds a live instruction.
REQ-008 SHALL have port is_branch / is_jal / is_jalr  in  1 each  decoded control-transfer kind.
REQ-009 SHALL have port funct3  in  3  branch condition code.
REQ-010 SHALL have port pc_ex  in  XLEN  PC of the EX instruction.
REQ-011 SHALL have port rs1_val, rs2_val  in  XLEN  forwarded operands.
REQ-012 SHALL have port bj_imm  in  XLEN  sign-extended branch/jump immediate from the EX pipeline register.
REQ-013 SHALL have port redirect  out  1  registered one-advance pulse: fetch must load redirect_pc.
REQ-014 SHALL have port redirect_pc  out  XLEN  registered target.
REQ-015 SHALL have port link_val  out  XLEN  registered pc_ex+4 for JAL/JALR writeback.
REQ-016 SHALL have port flush_if_id, flush_id_ex  out  1  registered squash to the IF/ID and ID/EX registers.
REQ-017 SHALL have port misalign_exc  out  1  registered one-advance pulse: taken target not 4-byte aligned.
REQ-018 SHALL have port taken_count  out  16  saturating count of redirects issued.

Function
REQ-019 SHALL sample inputs only on advance; with advance low all registers and outputs hold.
REQ-020 SHALL classify kind by priority is_jalr > is_jal > is_branch; none set = not a transfer.
REQ-021 SHALL evaluate conditions: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE; 010/011 = not taken.
REQ-022 SHALL compute target = pc_ex+bj_imm for branch/JAL; (rs1_val+bj_imm) with bit0 cleared for JALR; modulo 2^XLEN, carry discarded.
REQ-023 SHALL define taken = valid_ex & (JAL | JALR | (branch & condition true)) while FSM is IDLE.
REQ-024 SHALL implement FSM states IDLE and SQUASH with a squash counter.
REQ-025 IDLE, advance, taken, target[1:0]==00: next advance-edge sets redirect=1, redirect_pc=target, flush_if_id=flush_id_ex=1, counter=SQUASH_CYCLES-1, increment taken_count; go to SQUASH, or stay IDLE if SQUASH_CYCLES=1.
REQ-026 IDLE, advance, taken, target[1:0]!=00: set misalign_exc=1 for one advance, no redirect, no flush, no count; stay IDLE.
REQ-027 IDLE, advance, not taken: redirect, flush_*, misalign_exc = 0.
REQ-028 SQUASH, advance: redirect=0, flush_* stay 1; counter==0 -> clear flush_*, go IDLE; else decrement; valid_ex ignored (wrong-path).
REQ-029 SHALL update link_val = pc_ex+4 on every advance regardless of state.
REQ-030 taken_count SHALL saturate at 16'hFFFF.
REQ-031 Latency: decision visible one advance-edge after sampling; redirect high exactly one advance cycle; flush_* high exactly SQUASH_CYCLES advance cycles.

Reset
REQ-032 Reset SHALL take priority over advance and all inputs.
REQ-033 On Reset: FSM=IDLE, counter=0, redirect=0, redirect_pc=0, link_val=0, flush_*=0, misalign_exc=0, taken_count=0.
REQ-034 Reset during SQUASH SHALL abort squash; first post-reset advance evaluates valid_ex normally.

Verification
REQ-035 BEQ, pc_ex=0x100, imm=0x20, rs1=rs2=5, advance every cycle -> redirect 1 cycle, redirect_pc=0x120, flush_* 2 cycles, taken_count=1.
REQ-036 BLT, rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken, no flush.
REQ-037 JALR, rs1=0x203, imm=0 -> target 0x202, misalign_exc 1 cycle, no redirect, link_val=pc_ex+4.
REQ-038 JAL taken, then valid branch taken during SQUASH -> second ignored, taken_count=1.
REQ-039 JAL taken with Tick high every 3rd cycle -> redirect spans 3 clocks, flush_* 6 clocks; Reset asserted mid-SQUASH -> all outputs 0 next edge.
REQ-040 taken_count preloaded to 0xFFFF by 65535 JALs -> next JAL leaves 0xFFFF.

Source files
------------

// File: rtl/ex_branch_resolve.sv
// rtl/ex_branch_resolve.sv - EX-stage branch/jump resolution with fetch redirect and front-end squash
module ex_branch_resolve #(
    parameter int XLEN          = 32,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            ClockEnable,
    input  logic            Tick,
    input  logic            valid_ex,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] bj_imm,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] link_val,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            misalign_exc,
    output logic [15:0]     taken_count
);

    typedef enum logic {IDLE, SQUASH} state_t;

    localparam logic [1:0] SQ_INIT = 2'(SQUASH_CYCLES - 1);

    state_t          state;
    logic [1:0]      sq_cnt;
    logic            flush_q;
    logic            advance;
    logic            cond_true;
    logic            taken;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    assign advance = ClockEnable & Tick;

    always_comb begin
        cond_true = 1'b0;
        case (funct3)
            3'b000:  cond_true = (rs1_val == rs2_val);
            3'b001:  cond_true = (rs1_val != rs2_val);
            3'b100:  cond_true = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  cond_true = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  cond_true = (rs1_val <  rs2_val);
            3'b111:  cond_true = (rs1_val >= rs2_val);
            default: cond_true = 1'b0;
        endcase
    end

    // JALR takes precedence over JAL, which takes precedence over a conditional branch
    assign jalr_sum = rs1_val + bj_imm;
    assign target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_ex + bj_imm);
    assign taken    = valid_ex & (is_jalr | is_jal | (is_branch & cond_true));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            sq_cnt       <= 2'd0;
            redirect     <= 1'b0;
            redirect_pc  <= '0;
            link_val     <= '0;
            flush_q      <= 1'b0;
            misalign_exc <= 1'b0;
            taken_count  <= 16'd0;
        end else if (advance) begin
            link_val <= pc_ex + XLEN'(4);
            case (state)
                IDLE: begin
                    if (taken && target[1:0] == 2'b00) begin
                        redirect     <= 1'b1;
                        redirect_pc  <= target;
                        flush_q      <= 1'b1;
                        misalign_exc <= 1'b0;
                        sq_cnt       <= SQ_INIT;
                        if (taken_count != 16'hFFFF)
                            taken_count <= taken_count + 16'd1;
                        state <= (SQUASH_CYCLES == 1) ? IDLE : SQUASH;
                    end else begin
                        redirect     <= 1'b0;
                        flush_q      <= 1'b0;
                        misalign_exc <= taken;
                    end
                end
                SQUASH: begin
                    // EX holds a wrong-path instruction here, so valid_ex is not consulted
                    redirect     <= 1'b0;
                    misalign_exc <= 1'b0;
                    if (sq_cnt == 2'd0) begin
                        flush_q <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        sq_cnt <= sq_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign flush_if_id = flush_q;
    assign flush_id_ex = flush_q;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// tb/tb_ex_branch_resolve.sv - scoreboard bench for ex_branch_resolve
`timescale 1ns/1ps
module tb_ex_branch_resolve;

    logic        Clock = 1'b0;
    logic        Reset, ClockEnable, Tick;
    logic        valid_ex, v1, is_branch, is_jal, is_jalr;
    logic [2:0]  funct3;
    logic [31:0] pc_ex, rs1_val, rs2_val, bj_imm;

    logic        redirect, flush_if_id, flush_id_ex, misalign_exc;
    logic [31:0] redirect_pc, link_val;
    logic [15:0] taken_count;
    logic        redirect1, flush_if_id1, flush_id_ex1, misalign_exc1;
    logic [31:0] redirect_pc1, link_val1;
    logic [15:0] taken_count1;

    int total, bad, exp_cnt;
    logic [47:0] exp_rd[$];
    logic [31:0] exp_mis[$];
    logic [47:0] e_rd;
    logic [31:0] e_mis;
    logic        rd_prev = 1'b0, mis_prev = 1'b0;

    typedef struct packed {logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic tk;} cvec_t;
    cvec_t cv[8];

    ex_branch_resolve dut (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .valid_ex(valid_ex), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .pc_ex(pc_ex), .rs1_val(rs1_val), .rs2_val(rs2_val), .bj_imm(bj_imm),
        .redirect(redirect), .redirect_pc(redirect_pc), .link_val(link_val),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .misalign_exc(misalign_exc), .taken_count(taken_count)
    );

    ex_branch_resolve #(.XLEN(32), .SQUASH_CYCLES(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .valid_ex(v1), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .pc_ex(pc_ex), .rs1_val(rs1_val), .rs2_val(rs2_val), .bj_imm(bj_imm),
        .redirect(redirect1), .redirect_pc(redirect_pc1), .link_val(link_val1),
        .flush_if_id(flush_if_id1), .flush_id_ex(flush_id_ex1),
        .misalign_exc(misalign_exc1), .taken_count(taken_count1)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every new redirect / misalign pulse is matched against the scoreboard
    always @(negedge Clock) begin
        if (redirect && !rd_prev) begin
            if (exp_rd.size() == 0) chk("unexpected_redirect", 32'(redirect_pc), 32'hFFFF_FFFF);
            else begin
                e_rd = exp_rd.pop_front();
                chk("redirect_pc", redirect_pc, e_rd[31:0]);
                chk("taken_count_at_redirect", 32'(taken_count), 32'(e_rd[47:32]));
            end
        end
        if (misalign_exc && !mis_prev) begin
            if (exp_mis.size() == 0) chk("unexpected_misalign", link_val, 32'hFFFF_FFFF);
            else begin
                e_mis = exp_mis.pop_front();
                chk("misalign_link_val", link_val, e_mis);
            end
        end
        rd_prev  = redirect;
        mis_prev = misalign_exc;
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_in();
        valid_ex = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; funct3 = 3'd0;
    endtask

    task automatic expect_redirect(input logic [31:0] tgt);
        if (exp_cnt < 16'hFFFF) exp_cnt++;
        exp_rd.push_back({16'(exp_cnt), tgt});
    endtask

    task automatic fire();
        cyc();
        idle_in();
    endtask

    task automatic check_win(input string nm, input int n, input int er, input int ef, input int em);
        int r, f, m;
        r = 0; f = 0; m = 0;
        for (int i = 0; i < n; i++) begin
            r += int'(redirect);
            f += int'(flush_if_id & flush_id_ex);
            m += int'(misalign_exc);
            cyc();
        end
        chk({nm, "_redirect_cycles"}, r, er);
        chk({nm, "_flush_cycles"}, f, ef);
        chk({nm, "_misalign_cycles"}, m, em);
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm);
        idle_in();
        valid_ex = 1'b1; is_branch = 1'b1; funct3 = f3;
        rs1_val = a; rs2_val = b; pc_ex = pc; bj_imm = imm;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, f;
        total = 0; bad = 0; exp_cnt = 0;
        Reset = 1'b1; ClockEnable = 1'b1; Tick = 1'b1; v1 = 1'b0;
        idle_in();
        pc_ex = 0; rs1_val = 0; rs2_val = 0; bj_imm = 0;
        cyc(); cyc();
        chk("rst_redirect", 32'(redirect), 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_link_val", link_val, 0);
        chk("rst_flush", 32'({flush_if_id, flush_id_ex}), 0);
        chk("rst_misalign", 32'(misalign_exc), 0);
        chk("rst_taken_count", 32'(taken_count), 0);
        chk("rst_taken_count1", 32'(taken_count1), 0);
        Reset = 1'b0;

        // BEQ taken
        set_br(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
        expect_redirect(32'h120);
        fire();
        chk("beq_link_val", link_val, 32'h104);
        check_win("beq", 6, 1, 2, 0);
        chk("beq_taken_count", 32'(taken_count), 1);

        // BLT signed taken, BLTU same operands not taken
        set_br(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        expect_redirect(32'h240);
        fire();
        check_win("blt", 6, 1, 2, 0);
        set_br(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        fire();
        check_win("bltu", 4, 0, 0, 0);

        cv[0] = '{3'b001, 32'd5, 32'd5, 1'b0};
        cv[1] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0};
        cv[2] = '{3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1};
        cv[3] = '{3'b010, 32'd5, 32'd5, 1'b0};
        cv[4] = '{3'b000, 32'd5, 32'd6, 1'b0};
        cv[5] = '{3'b101, 32'd1, 32'hFFFF_FFFF, 1'b1};
        cv[6] = '{3'b001, 32'd5, 32'd6, 1'b1};
        cv[7] = '{3'b011, 32'd0, 32'd1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            set_br(cv[i].f3, cv[i].a, cv[i].b, 32'h300 + 32'(i) * 32'h10, 32'h8);
            if (cv[i].tk) expect_redirect(32'h308 + 32'(i) * 32'h10);
            fire();
            check_win($sformatf("cond%0d", i), 6, cv[i].tk ? 1 : 0, cv[i].tk ? 2 : 0, 0);
        end

        // JALR to a misaligned target
        idle_in(); valid_ex = 1'b1; is_jalr = 1'b1;
        rs1_val = 32'h203; bj_imm = 32'h0; pc_ex = 32'h400;
        exp_mis.push_back(32'h404);
        fire();
        chk("jalr_mis_link_val", link_val, 32'h404);
        check_win("jalr_mis", 4, 0, 0, 1);
        chk("jalr_mis_no_count", 32'(taken_count), 32'(exp_cnt));

        // JALR beats JAL and branch; bit 0 of the sum is cleared
        idle_in(); valid_ex = 1'b1; is_jalr = 1'b1; is_jal = 1'b1; is_branch = 1'b1;
        rs1_val = 32'h1001; rs2_val = 32'h0; bj_imm = 32'h10; pc_ex = 32'h500;
        expect_redirect(32'h1010);
        fire();
        check_win("jalr_prio", 6, 1, 2, 0);

        // JAL beats a not-taken branch; target wraps modulo 2^32
        idle_in(); valid_ex = 1'b1; is_jal = 1'b1; is_branch = 1'b1; funct3 = 3'b011;
        pc_ex = 32'hFFFF_FFF0; bj_imm = 32'h20;
        expect_redirect(32'h10);
        fire();
        chk("jal_wrap_link_val", link_val, 32'hFFFF_FFF4);
        check_win("jal_wrap", 6, 1, 2, 0);

        // JAL to a misaligned target
        idle_in(); valid_ex = 1'b1; is_jal = 1'b1; pc_ex = 32'h100; bj_imm = 32'h2;
        exp_mis.push_back(32'h104);
        fire();
        check_win("jal_mis", 4, 0, 0, 1);

        // No advance: everything holds
        idle_in(); valid_ex = 1'b1; is_jal = 1'b1; pc_ex = 32'h900; bj_imm = 32'h10;
        ClockEnable = 1'b0;
        cyc(); cyc(); cyc();
        chk("hold_ce_redirect", 32'(redirect), 0);
        chk("hold_ce_link_val", link_val, 32'h104);
        ClockEnable = 1'b1; Tick = 1'b0;
        cyc();
        chk("hold_tick_link_val", link_val, 32'h104);
        chk("hold_tick_count", 32'(taken_count), 32'(exp_cnt));
        Tick = 1'b1;
        idle_in();

        // Taken branch arriving during SQUASH is wrong-path
        idle_in(); valid_ex = 1'b1; is_jal = 1'b1; pc_ex = 32'h600; bj_imm = 32'h100;
        expect_redirect(32'h700);
        fire();
        set_br(3'b000, 32'd5, 32'd5, 32'h800, 32'h8);
        cyc(); cyc();
        idle_in();
        chk("squash_ignore_flush", 32'(flush_if_id), 0);
        chk("squash_ignore_count", 32'(taken_count), 32'(exp_cnt));

        // Slow advance: one tick every third clock
        idle_in(); valid_ex = 1'b1; is_jal = 1'b1; pc_ex = 32'hA00; bj_imm = 32'h40;
        expect_redirect(32'hA40);
        fire();
        r = 0; f = 0;
        for (int i = 0; i < 12; i++) begin
            r += int'(redirect);
            f += int'(flush_if_id & flush_id_ex);
            Tick = ((i % 3) == 2);
            cyc();
        end
        Tick = 1'b1;
        chk("tick3_redirect_clocks", r, 3);
        chk("tick3_flush_clocks", f, 6);

        // Reset in the middle of SQUASH, then a branch on the first post-reset advance
        idle_in(); valid_ex = 1'b1; is_jal = 1'b1; pc_ex = 32'hB00; bj_imm = 32'h80;
        expect_redirect(32'hB80);
        fire();
        chk("pre_reset_flush", 32'(flush_if_id), 1);
        Reset = 1'b1;
        cyc();
        chk("midrst_redirect", 32'(redirect), 0);
        chk("midrst_redirect_pc", redirect_pc, 0);
        chk("midrst_link_val", link_val, 0);
        chk("midrst_flush", 32'({flush_if_id, flush_id_ex}), 0);
        chk("midrst_misalign", 32'(misalign_exc), 0);
        chk("midrst_taken_count", 32'(taken_count), 0);
        exp_cnt = 0;
        Reset = 1'b0;
        set_br(3'b000, 32'd7, 32'd7, 32'hC00, 32'h10);
        expect_redirect(32'hC10);
        fire();
        check_win("post_reset", 6, 1, 2, 0);

        // Saturation on the single-cycle-squash instance
        idle_in(); is_jal = 1'b1; pc_ex = 32'h0; bj_imm = 32'h8; v1 = 1'b1;
        repeat (65535) cyc();
        chk("sat_count_ffff", 32'(taken_count1), 32'hFFFF);
        chk("sat_redirect_pc", redirect_pc1, 32'h8);
        chk("sat_flush", 32'(flush_if_id1 & flush_id_ex1), 1);
        cyc();
        chk("sat_count_hold", 32'(taken_count1), 32'hFFFF);
        v1 = 1'b0;
        cyc();
        chk("sq1_flush_clear", 32'(flush_if_id1 | flush_id_ex1), 0);
        chk("sq1_redirect_clear", 32'(redirect1), 0);
        chk("main_count_untouched", 32'(taken_count), 1);

        idle_in();
        cyc(); cyc();
        chk("redirect_queue_drained", 32'(exp_rd.size()), 0);
        chk("misalign_queue_drained", 32'(exp_mis.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
